seq_shift_add_multiplier: RTL

//   Parametrised, iterative radix-2 shift-add multiplier; successor to the fixed 4-bit

---
 rtl/seq_shift_add_multiplier.sv | 130 +++++++++++++
 1 files changed

// File: rtl/seq_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module  : seq_shift_add_multiplier
// Purpose : Iterative radix-2 shift-add multiplier, one multiplier bit per cycle,
//           optional signed mode, valid/ready on both sides.
// Rev     : 1.0
// ============================================================================
module seq_shift_add_multiplier #(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 in_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   mcand;
  logic               neg;
  // Upper half accumulates partial products; lower half holds the remaining
  // multiplier bits, which shift out as product bits shift in.
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH:0]     upper_sum;

  logic               mode_in;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               accept;
  logic               last_iter;

  // Operand conditioning; the most-negative value negates to itself,
  // which read as unsigned is exactly its magnitude.
  always_comb begin
    mode_in = SIGNED_EN && in_signed;
    a_mag   = (mode_in && a[WIDTH-1]) ? -a : a;
    b_mag   = (mode_in && b[WIDTH-1]) ? -b : b;
  end

  always_comb begin
    upper_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
              + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    acc_nxt   = {upper_sum, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    last_iter = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        last_iter = (cnt == LAST_ITER);
        if (cnt == LAST_ITER) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    busy = !in_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      mcand   <= '0;
      neg     <= 1'b0;
      acc     <= '0;
      product <= '0;
    end else begin
      if (accept) begin
        cnt   <= '0;
        mcand <= a_mag;
        neg   <= mode_in && (a[WIDTH-1] ^ b[WIDTH-1]);
        acc   <= {{WIDTH{1'b0}}, b_mag};
      end else if (state == S_RUN) begin
        cnt <= cnt + 1'b1;
        acc <= acc_nxt;
        if (last_iter) begin
          product <= neg ? -acc_nxt : acc_nxt;
        end
      end
    end
  end

endmodule
`default_nettype wire
